// File: rtl/riscvmulti_controller_if.sv
// riscvmulti_controller_if: control bus between the multicycle controller and its datapath/memory
// master: controller side (takes IR fields, flags and MemReady; drives enables and mux selects)
// slave: datapath side (mirror image of master)
interface riscvmulti_controller_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero;
  logic       Lt;
  logic       Ltu;
  logic       MemReady;
  logic       MemReq;
  logic       MemWrite;
  logic       AdrSrc;
  logic       IRWrite;
  logic       PCWrite;
  logic       RegWrite;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ResultSrc;
  logic [2:0] ImmSrc;
  logic [3:0] ALUControl;
  logic       Retire;
  logic       Trap;
  modport master (
    input  op, funct3, funct7b5, Zero, Lt, Ltu, MemReady,
    output MemReq, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
           ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl, Retire, Trap
  );
  modport slave (
    output op, funct3, funct7b5, Zero, Lt, Ltu, MemReady,
    input  MemReq, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
           ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl, Retire, Trap
  );
endinterface

// File: rtl/riscvmulti_controller.sv
// riscvmulti_controller: multicycle RV32I control FSM with memory wait, full branch set and illegal-opcode trap
// clk, reset: rising-edge clock, synchronous active-high reset (forces every output to 0 while high)
// bus: master modport of riscvmulti_controller_if (IR fields, ALU flags, MemReady in; enables/selects out)
module riscvmulti_controller #(
  parameter bit MEM_HANDSHAKE = 1'b1,
  parameter bit TRAP_ILLEGAL  = 1'b1
) (
  input logic clk,
  input logic reset,
  riscvmulti_controller_if.master bus
);
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_FENCE = 7'b0001111;
  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI,
    EXECU, ALUWB, BRANCH, JAL, JALR, JALRPC, TRAP
  } state_t;
  state_t state_q, state_d;
  logic rdy, taken;
  logic mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, retire, trap;
  logic [1:0] a_sel, b_sel, res_sel;
  logic [2:0] imm_sel;
  logic [3:0] alu_ctl;
  function automatic logic [3:0] alu_dec(input logic [2:0] f3, input logic sub, input logic sra);
    case (f3)
      3'b000:  return sub ? 4'b0001 : 4'b0000;
      3'b001:  return 4'b0111;
      3'b010:  return 4'b0101;
      3'b011:  return 4'b0110;
      3'b100:  return 4'b0100;
      3'b101:  return sra ? 4'b1001 : 4'b1000;
      3'b110:  return 4'b0011;
      default: return 4'b0010;
    endcase
  endfunction
  assign rdy = MEM_HANDSHAKE ? bus.MemReady : 1'b1;
  assign taken = (bus.funct3 == 3'b000) ?  bus.Zero :
                 (bus.funct3 == 3'b001) ? !bus.Zero :
                 (bus.funct3 == 3'b100) ?  bus.Lt :
                 (bus.funct3 == 3'b101) ? !bus.Lt :
                 (bus.funct3 == 3'b110) ?  bus.Ltu :
                 (bus.funct3 == 3'b111) ? !bus.Ltu : 1'b0;
  always_ff @(posedge clk)
    state_q <= reset ? FETCH : state_d;
  always_comb begin
    state_d   = state_q;
    mem_req   = 1'b0;
    mem_write = 1'b0;
    adr_src   = 1'b0;
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    reg_write = 1'b0;
    retire    = 1'b0;
    trap      = 1'b0;
    a_sel     = 2'b00;
    b_sel     = 2'b00;
    res_sel   = 2'b00;
    imm_sel   = 3'b000;
    alu_ctl   = 4'b0000;
    case (state_q)
      FETCH: begin
        mem_req  = 1'b1;
        b_sel    = 2'b10;
        res_sel  = 2'b10;
        ir_write = rdy;
        pc_write = rdy;
        state_d  = rdy ? DECODE : FETCH;
      end
      DECODE: begin
        // ALUOut captures the branch/jump target for BRANCH and JAL
        a_sel   = 2'b01;
        b_sel   = 2'b01;
        imm_sel = (bus.op == OP_JAL) ? 3'b011 : 3'b010;
        case (bus.op)
          OP_LOAD, OP_STORE: state_d = MEMADR;
          OP_R:              state_d = EXECR;
          OP_I:              state_d = EXECI;
          OP_LUI, OP_AUIPC:  state_d = EXECU;
          OP_BR:             state_d = BRANCH;
          OP_JAL:            state_d = JAL;
          OP_JALR:           state_d = JALR;
          OP_FENCE: begin
            state_d = FETCH;
            retire  = 1'b1;
          end
          default: begin
            state_d = TRAP_ILLEGAL ? TRAP : FETCH;
            retire  = !TRAP_ILLEGAL;
          end
        endcase
      end
      MEMADR: begin
        a_sel   = 2'b10;
        b_sel   = 2'b01;
        imm_sel = (bus.op == OP_STORE) ? 3'b001 : 3'b000;
        state_d = (bus.op == OP_STORE) ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
        state_d = rdy ? MEMWB : MEMREAD;
      end
      MEMWB: begin
        res_sel   = 2'b01;
        reg_write = 1'b1;
        retire    = 1'b1;
        state_d   = FETCH;
      end
      MEMWRITE: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        adr_src   = 1'b1;
        retire    = rdy;
        state_d   = rdy ? FETCH : MEMWRITE;
      end
      EXECR: begin
        a_sel   = 2'b10;
        alu_ctl = alu_dec(bus.funct3, bus.funct7b5, bus.funct7b5);
        state_d = ALUWB;
      end
      EXECI: begin
        a_sel   = 2'b10;
        b_sel   = 2'b01;
        alu_ctl = alu_dec(bus.funct3, 1'b0, bus.funct7b5);
        state_d = ALUWB;
      end
      EXECU: begin
        imm_sel = 3'b100;
        b_sel   = 2'b01;
        a_sel   = (bus.op == OP_LUI) ? 2'b10 : 2'b01;
        alu_ctl = (bus.op == OP_LUI) ? 4'b1010 : 4'b0000;
        state_d = ALUWB;
      end
      ALUWB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
        state_d   = FETCH;
      end
      BRANCH: begin
        a_sel    = 2'b10;
        alu_ctl  = 4'b0001;
        pc_write = taken;
        retire   = 1'b1;
        state_d  = FETCH;
      end
      JAL: begin
        // PC takes the target in ALUOut while the ALU forms the link value OldPC+4
        imm_sel  = 3'b011;
        a_sel    = 2'b01;
        b_sel    = 2'b10;
        pc_write = 1'b1;
        state_d  = ALUWB;
      end
      JALR: begin
        a_sel   = 2'b10;
        b_sel   = 2'b01;
        state_d = JALRPC;
      end
      JALRPC: begin
        a_sel    = 2'b01;
        b_sel    = 2'b10;
        pc_write = 1'b1;
        state_d  = ALUWB;
      end
      TRAP:    trap = 1'b1;
      default: state_d = FETCH;
    endcase
  end
  assign {bus.MemReq, bus.MemWrite, bus.AdrSrc, bus.IRWrite, bus.PCWrite, bus.RegWrite,
          bus.ALUSrcA, bus.ALUSrcB, bus.ResultSrc, bus.ImmSrc, bus.ALUControl, bus.Retire, bus.Trap} =
    reset ? '0 : {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
                  a_sel, b_sel, res_sel, imm_sel, alu_ctl, retire, trap};
endmodule

// File: tb/tb_riscvmulti_controller.sv
// tb_riscvmulti_controller: directed per-cycle output checks of riscvmulti_controller
module tb_riscvmulti_controller;
  // packed order: MemReq MemWrite AdrSrc IRWrite PCWrite RegWrite | A | B | Res | Imm | ALU | Retire Trap
  localparam logic [20:0] ZERO     = 21'h0;
  localparam logic [20:0] F_RDY    = {6'b100110, 2'b00, 2'b10, 2'b10, 3'b000, 4'b0000, 2'b00};
  localparam logic [20:0] F_WAIT   = {6'b100000, 2'b00, 2'b10, 2'b10, 3'b000, 4'b0000, 2'b00};
  localparam logic [20:0] DEC_B    = {6'b000000, 2'b01, 2'b01, 2'b00, 3'b010, 4'b0000, 2'b00};
  localparam logic [20:0] DEC_J    = {6'b000000, 2'b01, 2'b01, 2'b00, 3'b011, 4'b0000, 2'b00};
  localparam logic [20:0] DEC_RET  = {6'b000000, 2'b01, 2'b01, 2'b00, 3'b010, 4'b0000, 2'b10};
  localparam logic [20:0] EXR_ADD  = {6'b000000, 2'b10, 2'b00, 2'b00, 3'b000, 4'b0000, 2'b00};
  localparam logic [20:0] ALUWB    = {6'b000001, 2'b00, 2'b00, 2'b00, 3'b000, 4'b0000, 2'b10};
  localparam logic [20:0] MADR_L   = {6'b000000, 2'b10, 2'b01, 2'b00, 3'b000, 4'b0000, 2'b00};
  localparam logic [20:0] MADR_S   = {6'b000000, 2'b10, 2'b01, 2'b00, 3'b001, 4'b0000, 2'b00};
  localparam logic [20:0] MRD      = {6'b101000, 2'b00, 2'b00, 2'b00, 3'b000, 4'b0000, 2'b00};
  localparam logic [20:0] MWB      = {6'b000001, 2'b00, 2'b00, 2'b01, 3'b000, 4'b0000, 2'b10};
  localparam logic [20:0] MWR_WAIT = {6'b111000, 2'b00, 2'b00, 2'b00, 3'b000, 4'b0000, 2'b00};
  localparam logic [20:0] MWR_DONE = {6'b111000, 2'b00, 2'b00, 2'b00, 3'b000, 4'b0000, 2'b10};
  localparam logic [20:0] BR_NT    = {6'b000000, 2'b10, 2'b00, 2'b00, 3'b000, 4'b0001, 2'b10};
  localparam logic [20:0] BR_T     = {6'b000010, 2'b10, 2'b00, 2'b00, 3'b000, 4'b0001, 2'b10};
  localparam logic [20:0] JAL_S    = {6'b000010, 2'b01, 2'b10, 2'b00, 3'b011, 4'b0000, 2'b00};
  localparam logic [20:0] JALR_S   = {6'b000000, 2'b10, 2'b01, 2'b00, 3'b000, 4'b0000, 2'b00};
  localparam logic [20:0] JALRPC_S = {6'b000010, 2'b01, 2'b10, 2'b00, 3'b000, 4'b0000, 2'b00};
  localparam logic [20:0] TRAP_S   = 21'h1;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int total = 0;
  int bad = 0;
  riscvmulti_controller_if bus();
  riscvmulti_controller_if bus2();
  riscvmulti_controller dut (.clk(clk), .reset(reset), .bus(bus));
  riscvmulti_controller #(.MEM_HANDSHAKE(1'b1), .TRAP_ILLEGAL(1'b0)) dut_nop (.clk(clk), .reset(reset), .bus(bus2));
  assign bus2.op = bus.op;
  assign bus2.funct3 = bus.funct3;
  assign bus2.funct7b5 = bus.funct7b5;
  assign bus2.Zero = bus.Zero;
  assign bus2.Lt = bus.Lt;
  assign bus2.Ltu = bus.Ltu;
  assign bus2.MemReady = bus.MemReady;
  logic [20:0] o1, o2;
  assign o1 = {bus.MemReq, bus.MemWrite, bus.AdrSrc, bus.IRWrite, bus.PCWrite, bus.RegWrite,
               bus.ALUSrcA, bus.ALUSrcB, bus.ResultSrc, bus.ImmSrc, bus.ALUControl, bus.Retire, bus.Trap};
  assign o2 = {bus2.MemReq, bus2.MemWrite, bus2.AdrSrc, bus2.IRWrite, bus2.PCWrite, bus2.RegWrite,
               bus2.ALUSrcA, bus2.ALUSrcB, bus2.ResultSrc, bus2.ImmSrc, bus2.ALUControl, bus2.Retire, bus2.Trap};
  always #5 clk = ~clk;
  task automatic set_ir(input logic [6:0] op, input logic [2:0] f3, input logic f7);
    bus.op = op;
    bus.funct3 = f3;
    bus.funct7b5 = f7;
  endtask
  task automatic test_reset;
    logic [20:0] ex [4];
    ex = '{F_RDY, DEC_B, EXR_ADD, ALUWB};
    set_ir(7'b0110011, 3'b000, 1'b0);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      total++;
      if (o1 !== ZERO) begin bad++; $display("FAIL reset c%0d got=%h exp=%h", i, o1, ZERO); end
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 0) reset = 1'b0;
      #1;
      total++;
      if (o1 !== ex[i]) begin bad++; $display("FAIL add c%0d got=%h exp=%h", i, o1, ex[i]); end
    end
  endtask
  task automatic test_alu;
    logic [6:0] ops [7];
    logic [2:0] f3s [7];
    logic f7s [7];
    logic [20:0] exv [7];
    logic [20:0] e;
    ops = '{7'b0110011, 7'b0110011, 7'b0010011, 7'b0010011, 7'b0110111, 7'b0010111, 7'b0110011};
    f3s = '{3'b000, 3'b000, 3'b000, 3'b101, 3'b000, 3'b000, 3'b011};
    f7s = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    exv = '{EXR_ADD,
            {6'b0, 2'b10, 2'b00, 2'b00, 3'b000, 4'b0001, 2'b00},
            {6'b0, 2'b10, 2'b01, 2'b00, 3'b000, 4'b0000, 2'b00},
            {6'b0, 2'b10, 2'b01, 2'b00, 3'b000, 4'b1001, 2'b00},
            {6'b0, 2'b10, 2'b01, 2'b00, 3'b100, 4'b1010, 2'b00},
            {6'b0, 2'b01, 2'b01, 2'b00, 3'b100, 4'b0000, 2'b00},
            {6'b0, 2'b10, 2'b00, 2'b00, 3'b000, 4'b0110, 2'b00}};
    for (int k = 0; k < 7; k++) begin
      set_ir(ops[k], f3s[k], f7s[k]);
      for (int c = 0; c < 4; c++) begin
        e = (c == 0) ? F_RDY : (c == 1) ? DEC_B : (c == 2) ? exv[k] : ALUWB;
        @(negedge clk);
        #1;
        total++;
        if (o1 !== e) begin bad++; $display("FAIL alu k%0d c%0d got=%h exp=%h", k, c, o1, e); end
      end
    end
  endtask
  task automatic test_load;
    logic [20:0] ex [7];
    logic rdy [7];
    ex = '{F_RDY, DEC_B, MADR_L, MRD, MRD, MRD, MWB};
    rdy = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    set_ir(7'b0000011, 3'b010, 1'b0);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      bus.MemReady = rdy[i];
      #1;
      total++;
      if (o1 !== ex[i]) begin bad++; $display("FAIL load c%0d got=%h exp=%h", i, o1, ex[i]); end
    end
  endtask
  task automatic test_store;
    logic [20:0] ex [5];
    logic rdy [5];
    ex = '{F_WAIT, F_RDY, DEC_B, MADR_S, MWR_DONE};
    rdy = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    set_ir(7'b0100011, 3'b010, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.MemReady = rdy[i];
      #1;
      total++;
      if (o1 !== ex[i]) begin bad++; $display("FAIL store c%0d got=%h exp=%h", i, o1, ex[i]); end
    end
  endtask
  task automatic test_branch;
    logic [2:0] f3s [6];
    logic zs [6];
    logic lts [6];
    logic ltus [6];
    logic [20:0] exv [6];
    logic [20:0] e;
    f3s  = '{3'b001, 3'b001, 3'b110, 3'b101, 3'b010, 3'b000};
    zs   = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    lts  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    ltus = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    exv  = '{BR_NT, BR_T, BR_T, BR_NT, BR_NT, BR_T};
    for (int k = 0; k < 6; k++) begin
      set_ir(7'b1100011, f3s[k], 1'b0);
      bus.Zero = zs[k];
      bus.Lt = lts[k];
      bus.Ltu = ltus[k];
      for (int c = 0; c < 3; c++) begin
        e = (c == 0) ? F_RDY : (c == 1) ? DEC_B : exv[k];
        @(negedge clk);
        #1;
        total++;
        if (o1 !== e) begin bad++; $display("FAIL branch k%0d c%0d got=%h exp=%h", k, c, o1, e); end
      end
    end
    bus.Zero = 1'b0;
    bus.Lt = 1'b0;
    bus.Ltu = 1'b0;
  endtask
  task automatic test_jal;
    logic [20:0] ex [4];
    ex = '{F_RDY, DEC_J, JAL_S, ALUWB};
    set_ir(7'b1101111, 3'b000, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      total++;
      if (o1 !== ex[i]) begin bad++; $display("FAIL jal c%0d got=%h exp=%h", i, o1, ex[i]); end
    end
  endtask
  task automatic test_jalr;
    logic [20:0] ex [5];
    ex = '{F_RDY, DEC_B, JALR_S, JALRPC_S, ALUWB};
    set_ir(7'b1100111, 3'b000, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      total++;
      if (o1 !== ex[i]) begin bad++; $display("FAIL jalr c%0d got=%h exp=%h", i, o1, ex[i]); end
    end
  endtask
  task automatic test_trap;
    logic [20:0] e;
    set_ir(7'b1111111, 3'b000, 1'b0);
    for (int i = 0; i < 13; i++) begin
      e = (i == 0) ? F_RDY : (i == 1) ? DEC_B : (i == 12) ? ZERO : TRAP_S;
      @(negedge clk);
      if (i == 12) reset = 1'b1;
      #1;
      total++;
      if (o1 !== e) begin bad++; $display("FAIL trap c%0d got=%h exp=%h", i, o1, e); end
      if (i < 3) begin
        e = (i == 1) ? DEC_RET : F_RDY;
        total++;
        if (o2 !== e) begin bad++; $display("FAIL nop c%0d got=%h exp=%h", i, o2, e); end
      end
    end
  endtask
  task automatic test_store_reset;
    logic [20:0] ex [7];
    logic rdy [7];
    logic rst [7];
    ex  = '{F_RDY, DEC_B, MADR_S, MWR_WAIT, MWR_WAIT, ZERO, F_RDY};
    rdy = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    rst = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    set_ir(7'b0100011, 3'b010, 1'b0);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      reset = rst[i];
      bus.MemReady = rdy[i];
      #1;
      total++;
      if (o1 !== ex[i]) begin bad++; $display("FAIL store_reset c%0d got=%h exp=%h", i, o1, ex[i]); end
      total++;
      if (o2 !== ex[i]) begin bad++; $display("FAIL store_reset_nop c%0d got=%h exp=%h", i, o2, ex[i]); end
    end
  endtask
  initial begin
    set_ir(7'b0110011, 3'b000, 1'b0);
    bus.Zero = 1'b0;
    bus.Lt = 1'b0;
    bus.Ltu = 1'b0;
    bus.MemReady = 1'b1;
    test_reset;
    test_alu;
    test_load;
    test_store;
    test_branch;
    test_jal;
    test_jalr;
    test_trap;
    test_store_reset;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
